// File: rtl/gray_counter.sv
// Up/down counter holding its state in Gray code.
// Gray and binary views are registered from one binary next-state.
module gray_counter #(
    parameter int SIZE = 8,
    parameter int SAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            up,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
    output logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin,
    output logic            wrap,
    output logic            at_max,
    output logic            at_min
);

    localparam logic [SIZE-1:0] MAX = '1;
    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] gray_q;
    logic            wrap_q;
    logic [SIZE-1:0] next_bin;
    logic            next_wrap;
    logic            is_max;
    logic            is_min;

    function automatic logic [SIZE-1:0] bin2gray(
        input logic [SIZE-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    assign is_max = (bin_q == MAX);
    assign is_min = (bin_q == '0);

    // Next binary count: load beats count beats hold.
    always_comb begin
        next_bin  = bin_q;
        next_wrap = 1'b0;
        unique case (1'b1)
            load: begin
                next_bin = load_bin;
            end
            (!load && en && up): begin
                if (!is_max) begin
                    next_bin = bin_q + ONE;
                end else if (SAT == 0) begin
                    next_bin  = '0;
                    next_wrap = 1'b1;
                end
            end
            (!load && en && !up): begin
                if (!is_min) begin
                    next_bin = bin_q - ONE;
                end else if (SAT == 0) begin
                    next_bin  = MAX;
                    next_wrap = 1'b1;
                end
            end
            default: begin
                next_bin = bin_q;
            end
        endcase
    end

    // Both encodings latch the same next value, so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= bin2gray(next_bin);
            wrap_q <= next_wrap;
        end
    end

    assign gray   = gray_q;
    assign bin    = bin_q;
    assign wrap   = wrap_q;
    assign at_max = (bin_q == MAX);
    assign at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (5-bit wrap, 5-bit saturate,
// 8-bit wrap) share stimulus and are checked against an integer model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lb = 8'd0;

    logic [4:0] g0, b0, g1, b1;
    logic [7:0] g2, b2;
    logic       w0, w1, w2;
    logic       mx0, mx1, mx2;
    logic       mn0, mn1, mn2;

    int nvec = 0;
    int nerr = 0;

    int sz[3]  = '{5, 5, 8};
    int sat[3] = '{0, 1, 0};
    int mb[3]  = '{0, 0, 0};
    int mw[3]  = '{0, 0, 0};
    bit stp[3] = '{0, 0, 0};
    int pg[3]  = '{0, 0, 0};
    bit hp[3]  = '{0, 0, 0};

    always #5 clk = ~clk;

    gray_counter #(.SIZE(5), .SAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up),
        .load(load), .load_bin(lb[4:0]),
        .gray(g0), .bin(b0), .wrap(w0),
        .at_max(mx0), .at_min(mn0)
    );

    gray_counter #(.SIZE(5), .SAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up),
        .load(load), .load_bin(lb[4:0]),
        .gray(g1), .bin(b1), .wrap(w1),
        .at_max(mx1), .at_min(mn1)
    );

    gray_counter #(.SIZE(8), .SAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up),
        .load(load), .load_bin(lb),
        .gray(g2), .bin(b2), .wrap(w2),
        .at_max(mx2), .at_min(mn2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int dut_g(input int k);
        case (k)
            0: return int'(g0);
            1: return int'(g1);
            default: return int'(g2);
        endcase
    endfunction

    function automatic int dut_b(input int k);
        case (k)
            0: return int'(b0);
            1: return int'(b1);
            default: return int'(b2);
        endcase
    endfunction

    function automatic int dut_f(input int k, input int which);
        logic [2:0] w, x, n;
        w = {w2, w1, w0};
        x = {mx2, mx1, mx0};
        n = {mn2, mn1, mn0};
        case (which)
            0: return int'(w[k]);
            1: return int'(x[k]);
            default: return int'(n[k]);
        endcase
    endfunction

    // Reference: plain modular arithmetic on the count value.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            int top;
            int nb;
            top = (1 << sz[k]) - 1;
            stp[k] = 1'b0;
            if (!rst_n) begin
                mb[k] = 0;
                mw[k] = 0;
            end else if (load) begin
                mb[k] = int'(lb) % (top + 1);
                mw[k] = 0;
            end else if (en) begin
                nb = up ? mb[k] + 1 : mb[k] - 1;
                mw[k] = 0;
                if (nb > top || nb < 0) begin
                    if (sat[k] != 0) begin
                        nb = mb[k];
                    end else begin
                        nb = (nb + top + 1) % (top + 1);
                        mw[k] = 1;
                    end
                end
                stp[k] = (nb != mb[k]);
                mb[k] = nb;
            end else begin
                mw[k] = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int top;
            int eg;
            top = (1 << sz[k]) - 1;
            eg = mb[k] ^ (mb[k] >> 1);
            chk($sformatf("bin[%0d]", k), dut_b(k), mb[k]);
            chk($sformatf("gray[%0d]", k), dut_g(k), eg);
            chk($sformatf("wrap[%0d]", k), dut_f(k, 0), mw[k]);
            chk($sformatf("at_max[%0d]", k), dut_f(k, 1),
                int'(mb[k] == top));
            chk($sformatf("at_min[%0d]", k), dut_f(k, 2),
                int'(mb[k] == 0));
            if (stp[k] && hp[k])
                chk($sformatf("onebit[%0d]", k),
                    $countones(dut_g(k) ^ pg[k]), 1);
            pg[k] = dut_g(k);
            hp[k] = rst_n;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_bin", int'(b0), 0);
        chk("rst_at_min", int'(mn0), 1);
        cyc(2);
        rst_n = 1'b1;

        // Async reset mid-count.
        en = 1'b1;
        up = 1'b1;
        cyc(5);
        chk("pre_rst_bin", int'(b0), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_gray", int'(g0), 0);
        chk("async_bin", int'(b0), 0);
        chk("async_min", int'(mn0), 1);
        chk("async_max", int'(mx0), 0);
        cyc();
        rst_n = 1'b1;

        // Up-count through rollover.
        cyc();
        chk("up1_gray", int'(g0), 5'b00001);
        cyc();
        chk("up2_gray", int'(g0), 5'b00011);
        cyc(29);
        chk("up31_bin", int'(b0), 31);
        chk("up31_gray", int'(g0), 5'b10000);
        chk("up31_max", int'(mx0), 1);
        cyc();
        chk("roll_bin", int'(b0), 0);
        chk("roll_gray", int'(g0), 0);
        chk("roll_wrap", int'(w0), 1);
        chk("sat_nowrap", int'(w1), 0);
        chk("sat_hold", int'(b1), 31);
        cyc();
        chk("post_wrap", int'(w0), 0);
        chk("post_bin", int'(b0), 1);

        // Load beats count.
        load = 1'b1;
        lb = 8'd31;
        cyc();
        chk("ld31_bin", int'(b0), 31);
        chk("ld31_gray", int'(g0), 5'b10000);
        chk("ld31_wrap", int'(w0), 0);
        lb = 8'd1;
        cyc();
        chk("ld1_gray", int'(g0), 5'b00001);
        lb = 8'd21;
        cyc();
        chk("ld21_gray", int'(g0), 5'b11111);

        // Down-count through rollover.
        lb = 8'd1;
        cyc();
        load = 1'b0;
        up = 1'b0;
        cyc();
        chk("dn0_bin", int'(b0), 0);
        chk("dn0_wrap", int'(w0), 0);
        cyc();
        chk("dn31_bin", int'(b0), 31);
        chk("dn31_gray", int'(g0), 5'b10000);
        chk("dn31_wrap", int'(w0), 1);
        chk("satdn_bin", int'(b1), 0);
        chk("satdn_wrap", int'(w1), 0);

        // Saturation at the top and bottom.
        load = 1'b1;
        lb = 8'd30;
        cyc();
        load = 1'b0;
        up = 1'b1;
        cyc(3);
        chk("sattop_bin", int'(b1), 31);
        chk("sattop_gray", int'(g1), 5'b10000);
        chk("sattop_max", int'(mx1), 1);
        load = 1'b1;
        lb = 8'd1;
        cyc();
        load = 1'b0;
        up = 1'b0;
        cyc(3);
        chk("satbot_bin", int'(b1), 0);
        chk("satbot_min", int'(mn1), 1);

        // Hold and direction reversal on the 8-bit counter.
        load = 1'b1;
        lb = 8'h7F;
        cyc();
        load = 1'b0;
        up = 1'b1;
        en = 1'b1;
        cyc();
        chk("h80_bin", int'(b2), 8'h80);
        chk("h80_gray", int'(g2), 8'hC0);
        en = 1'b0;
        cyc();
        chk("hold_bin", int'(b2), 8'h80);
        en = 1'b1;
        cyc();
        chk("h81_bin", int'(b2), 8'h81);
        chk("h81_gray", int'(g2), 8'hC1);
        up = 1'b0;
        cyc();
        chk("rev80_bin", int'(b2), 8'h80);
        cyc();
        chk("rev7f_bin", int'(b2), 8'h7F);
        chk("rev7f_gray", int'(g2), 8'h40);

        // Mixed stimulus, checked by the model only.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 4) != 0);
            load = ($urandom_range(0, 15) == 0);
            lb = 8'($urandom_range(0, 255));
            cyc();
        end
        en = 1'b0;
        load = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
